// File: rtl/pcs_descr_pkg.sv
// Shared constants, state encoding and legal block-type lookup for the
// 64b/66b receive descrambler.
package pcs_descr_pkg;

    // Sync header encodings, bit [0] in the LSB of the 2-bit field.
    localparam logic [1:0] SH_DATA = 2'b10;
    localparam logic [1:0] SH_CTRL = 2'b01;

    // Descrambler polynomial x^58 + x^39 + 1, expressed as tap distances.
    localparam int TAP_A  = 39;
    localparam int TAP_B  = 58;
    localparam int HIST_W = TAP_B;

    // Payload width of one 64b/66b block.
    localparam int PAYLOAD_W = 64;

    // Descrambler trust state.
    typedef enum logic {
        UNSYNC = 1'b0,
        SYNC   = 1'b1
    } desc_state_t;

    // True when the control block-type byte is one of the defined codes.
    function automatic logic blk_type_legal(input logic [7:0] blk_type);
        logic legal;
        legal = 1'b0;
        case (blk_type)
            8'h1E, 8'h2D, 8'h33, 8'h66, 8'h55,
            8'h78, 8'h4B, 8'h87, 8'h99, 8'hAA,
            8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF: legal = 1'b1;
            default:                           legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/pcs_blk_type_chk.sv
// Combinational check of a control block-type byte against the legal set.
module pcs_blk_type_chk
    import pcs_descr_pkg::*;
(
    input  logic [7:0] blk_type,
    output logic       illegal
);

    assign illegal = ~blk_type_legal(blk_type);

endmodule

// File: rtl/pcs_descramble.sv
// 64b/66b receive descrambler (x^58 + x^39 + 1, self-synchronising) with
// sync-header / block-type checking and a saturating errored-block counter.
// Optional feature macro: PCS_DESCRAMBLE_BYPASS_EN adds a BYPASS input that
// passes the payload through unmodified while everything else runs as usual.
module pcs_descramble
    import pcs_descr_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int CHECK_TYPE = 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [65:0]      PCS_BLK,
    input  logic             PCS_BLK_ENA,
    input  logic             RESYNC,
    input  logic             CNT_CLR,
`ifdef PCS_DESCRAMBLE_BYPASS_EN
    input  logic             BYPASS,
`endif
    output logic [65:0]      DESC_BLK,
    output logic             DESC_BLK_ENA,
    output logic             DESC_SYNCED,
    output logic             SH_ERR,
    output logic             BLK_TYPE_ERR,
    output logic [CNT_W-1:0] ERR_CNT
);

    // Chronological history: hist_reg[0] is the oldest scrambled bit,
    // hist_reg[HIST_W-1] the most recently received one.
    logic [HIST_W-1:0]           hist_reg;
    logic [HIST_W-1:0]           hist_next;
    desc_state_t                 state_reg;
    desc_state_t                 state_next;

    logic [1:0]                  hdr;
    logic [PAYLOAD_W-1:0]        payload_in;
    logic [PAYLOAD_W-1:0]        payload_desc;
    logic [PAYLOAD_W-1:0]        payload_out;
    logic [PAYLOAD_W+HIST_W-1:0] chain;

    logic                        synced_next;
    logic                        sh_err_next;
    logic                        type_illegal;
    logic                        type_err_next;
    logic                        cnt_inc;

    logic [65:0]                 desc_blk_reg;
    logic                        desc_ena_reg;
    logic                        synced_reg;
    logic                        sh_err_reg;
    logic                        type_err_reg;
    logic [CNT_W-1:0]            err_cnt_reg;

    assign hdr        = PCS_BLK[1:0];
    assign payload_in = PCS_BLK[65:2];

    // Stream of scrambled bits in arrival order: history first, then the new
    // payload with bit 0 (PCS_BLK[2]) arriving first.
    assign chain = {payload_in, hist_reg};

    // Unrolled descrambler: each output bit uses the scrambled bits that
    // arrived TAP_A and TAP_B positions earlier in the stream.
    generate
        for (genvar gi = 0; gi < PAYLOAD_W; gi++) begin : g_desc
            assign payload_desc[gi] = chain[gi + HIST_W]
                                    ^ chain[gi + HIST_W - TAP_A]
                                    ^ chain[gi + HIST_W - TAP_B];
        end
    endgenerate

    // After a block the history is simply the newest HIST_W scrambled bits.
    assign hist_next = payload_in[PAYLOAD_W-1 -: HIST_W];

`ifdef PCS_DESCRAMBLE_BYPASS_EN
    assign payload_out = BYPASS ? payload_in : payload_desc;
`else
    assign payload_out = payload_desc;
`endif

    pcs_blk_type_chk u_type_chk (
        .blk_type (payload_desc[7:0]),
        .illegal  (type_illegal)
    );

    // Header 01 is never a header error, so a header error already excludes
    // a block-type error here.
    assign sh_err_next   = (hdr == 2'b00) || (hdr == 2'b11);
    assign type_err_next = (CHECK_TYPE != 0) && (hdr == SH_CTRL) && type_illegal;
    assign cnt_inc       = PCS_BLK_ENA && synced_next && (sh_err_next || type_err_next);

    // Next-state and trust decision; RESYNC distrusts the coincident block.
    always_comb begin
        state_next  = state_reg;
        synced_next = 1'b0;
        if (PCS_BLK_ENA) begin
            synced_next = (state_reg == SYNC) && !RESYNC;
        end
        if (RESYNC) begin
            state_next = UNSYNC;
        end else if (PCS_BLK_ENA) begin
            state_next = SYNC;
        end
    end

    // State and history registers; history advances only with valid blocks.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_reg <= UNSYNC;
            hist_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (PCS_BLK_ENA) begin
                hist_reg <= hist_next;
            end
        end
    end

    // Output block register: one cycle of latency, holds through gaps.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            desc_blk_reg <= '0;
            desc_ena_reg <= 1'b0;
            synced_reg   <= 1'b0;
            sh_err_reg   <= 1'b0;
            type_err_reg <= 1'b0;
        end else begin
            desc_ena_reg <= PCS_BLK_ENA;
            if (PCS_BLK_ENA) begin
                desc_blk_reg <= {payload_out, hdr};
                synced_reg   <= synced_next;
                sh_err_reg   <= sh_err_next;
                type_err_reg <= type_err_next;
            end
        end
    end

    // Saturating errored-block counter; clear takes priority over increment.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            err_cnt_reg <= '0;
        end else if (CNT_CLR) begin
            err_cnt_reg <= '0;
        end else if (cnt_inc && (err_cnt_reg != {CNT_W{1'b1}})) begin
            err_cnt_reg <= err_cnt_reg + 1'b1;
        end
    end

    assign DESC_BLK     = desc_blk_reg;
    assign DESC_BLK_ENA = desc_ena_reg;
    assign DESC_SYNCED  = synced_reg;
    assign SH_ERR       = sh_err_reg;
    assign BLK_TYPE_ERR = type_err_reg;
    assign ERR_CNT      = err_cnt_reg;

endmodule

// File: tb/tb_pcs_descramble.sv
// Directed bench for pcs_descramble: a reference scrambler produces the line
// blocks, expected outputs are the known plain payloads and flag values.
module tb_pcs_descramble;

    localparam logic [1:0]  SH_D = 2'b10;
    localparam logic [1:0]  SH_C = 2'b01;
    localparam logic [63:0] IDLE = 64'h0000_0000_0000_001E;
    localparam logic [63:0] DATA = 64'h0123_4567_89AB_CDEF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [65:0] pcs_blk;
    logic        pcs_blk_ena;
    logic        resync;
    logic        cnt_clr;

    logic [65:0] desc_blk;
    logic        desc_blk_ena;
    logic        desc_synced;
    logic        sh_err;
    logic        blk_type_err;
    logic [3:0]  err_cnt;

    logic [65:0] nc_desc_blk;
    logic        nc_desc_blk_ena;
    logic        nc_desc_synced;
    logic        nc_sh_err;
    logic        nc_blk_type_err;
    logic [3:0]  nc_err_cnt;

    logic [57:0] tx_s;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    pcs_descramble #(.CNT_W(4), .CHECK_TYPE(1)) dut (
        .CLK          (clk),
        .RST_N        (rst_n),
        .PCS_BLK      (pcs_blk),
        .PCS_BLK_ENA  (pcs_blk_ena),
        .RESYNC       (resync),
        .CNT_CLR      (cnt_clr),
`ifdef PCS_DESCRAMBLE_BYPASS_EN
        .BYPASS       (1'b0),
`endif
        .DESC_BLK     (desc_blk),
        .DESC_BLK_ENA (desc_blk_ena),
        .DESC_SYNCED  (desc_synced),
        .SH_ERR       (sh_err),
        .BLK_TYPE_ERR (blk_type_err),
        .ERR_CNT      (err_cnt)
    );

    pcs_descramble #(.CNT_W(4), .CHECK_TYPE(0)) dut_nc (
        .CLK          (clk),
        .RST_N        (rst_n),
        .PCS_BLK      (pcs_blk),
        .PCS_BLK_ENA  (pcs_blk_ena),
        .RESYNC       (resync),
        .CNT_CLR      (cnt_clr),
`ifdef PCS_DESCRAMBLE_BYPASS_EN
        .BYPASS       (1'b0),
`endif
        .DESC_BLK     (nc_desc_blk),
        .DESC_BLK_ENA (nc_desc_blk_ena),
        .DESC_SYNCED  (nc_desc_synced),
        .SH_ERR       (nc_sh_err),
        .BLK_TYPE_ERR (nc_blk_type_err),
        .ERR_CNT      (nc_err_cnt)
    );

    // Transmit-side scrambler: feeds back its own scrambled output bits.
    task automatic scramble(input logic [63:0] plain, output logic [63:0] scr);
        for (int i = 0; i < 64; i++) begin
            scr[i] = plain[i] ^ tx_s[38] ^ tx_s[57];
            tx_s   = {tx_s[56:0], scr[i]};
        end
    endtask

    // Apply one cycle of input; outputs are sampled 1 time unit after the edge.
    task automatic drive(input logic ena, input logic [1:0] hdr, input logic [63:0] plain);
        logic [63:0] scr;
        if (ena) scramble(plain, scr);
        else     scr = 64'hDEAD_BEEF_DEAD_BEEF;
        pcs_blk     = {scr, hdr};
        pcs_blk_ena = ena;
        @(posedge clk);
        #1;
        $display("blk ena=%0b rs=%0b clr=%0b hdr=%b -> out_ena=%0b sync=%0b sh=%0b ty=%0b cnt=%0d blk=%h",
                 ena, resync, cnt_clr, hdr, desc_blk_ena, desc_synced, sh_err, blk_type_err, err_cnt, desc_blk);
    endtask

    task automatic clear_counter();
        cnt_clr = 1'b1;
        drive(1'b0, SH_D, 64'h0);
        cnt_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; resync = 1'b0; cnt_clr = 1'b0;
        drive(1'b0, SH_D, 64'h0);
        drive(1'b0, SH_D, 64'h0);
        n_vec++;
        if ({desc_blk, desc_blk_ena, desc_synced, sh_err, blk_type_err, err_cnt} !== 75'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got blk=%h ena=%b sync=%b sh=%b ty=%b cnt=%h, want all 0",
                     desc_blk, desc_blk_ena, desc_synced, sh_err, blk_type_err, err_cnt);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_idle_stream();
        tx_s = 58'h3FF_FFFF_FFFF_FFFF;
        for (int b = 1; b <= 10; b++) begin
            drive(1'b1, SH_C, IDLE);
            n_vec++;
            if (desc_blk_ena !== 1'b1) begin
                n_err++; $display("FAIL idle_ena blk%0d: got %b want 1", b, desc_blk_ena);
            end
            n_vec++;
            if (desc_synced !== (b != 1)) begin
                n_err++; $display("FAIL idle_synced blk%0d: got %b want %b", b, desc_synced, b != 1);
            end
            if (b != 1) begin
                n_vec++;
                if (desc_blk !== {IDLE, SH_C} || blk_type_err !== 1'b0) begin
                    n_err++; $display("FAIL idle_data blk%0d: got %h ty=%b want %h ty=0", b, desc_blk, blk_type_err, {IDLE, SH_C});
                end
            end
        end
        n_vec++;
        if (err_cnt !== 4'h0) begin
            n_err++; $display("FAIL idle_cnt: got %h want 0", err_cnt);
        end
    endtask

    task automatic test_gaps();
        logic [1:0] ena_seq [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [63:0] pl;
        for (int k = 0; k < 4; k++) begin
            pl = DATA ^ 64'(k);
            drive(ena_seq[k][0], SH_D, pl);
            n_vec++;
            if (desc_blk_ena !== ena_seq[k][0]) begin
                n_err++; $display("FAIL gap_ena step%0d: got %b want %b", k, desc_blk_ena, ena_seq[k][0]);
            end
            n_vec++;
            // During the gaps the previous (step 0) block must be held.
            if (desc_blk !== {(k == 3) ? (DATA ^ 64'd3) : DATA, SH_D}) begin
                n_err++; $display("FAIL gap_blk step%0d: got %h", k, desc_blk);
            end
        end
        n_vec++;
        if (desc_synced !== 1'b1) begin
            n_err++; $display("FAIL gap_synced: got %b want 1", desc_synced);
        end
    endtask

    task automatic test_header_errors();
        logic [1:0] hdrs [3] = '{2'b00, 2'b11, SH_D};
        logic [3:0] cnts [3] = '{4'd1, 4'd2, 4'd2};
        clear_counter();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, hdrs[k], DATA);
            n_vec++;
            if (sh_err !== (k != 2) || blk_type_err !== 1'b0) begin
                n_err++; $display("FAIL sh_flag hdr=%b: got sh=%b ty=%b want sh=%b ty=0", hdrs[k], sh_err, blk_type_err, k != 2);
            end
            n_vec++;
            if (err_cnt !== cnts[k] || desc_blk !== {DATA, hdrs[k]}) begin
                n_err++; $display("FAIL sh_cnt hdr=%b: got cnt=%h blk=%h want cnt=%h", hdrs[k], err_cnt, desc_blk, cnts[k]);
            end
        end
    endtask

    task automatic test_illegal_type();
        clear_counter();
        drive(1'b1, SH_C, 64'h0);
        n_vec++;
        if (blk_type_err !== 1'b1 || err_cnt !== 4'd1 || desc_blk !== {64'h0, SH_C}) begin
            n_err++; $display("FAIL type00: got ty=%b cnt=%h blk=%h want ty=1 cnt=1", blk_type_err, err_cnt, desc_blk);
        end
        n_vec++;
        if (nc_blk_type_err !== 1'b0 || nc_err_cnt !== 4'd0) begin
            n_err++; $display("FAIL type00_nocheck: got ty=%b cnt=%h want ty=0 cnt=0", nc_blk_type_err, nc_err_cnt);
        end
        drive(1'b1, SH_C, 64'h0000_0000_0000_00FF);
        n_vec++;
        if (blk_type_err !== 1'b0 || err_cnt !== 4'd1) begin
            n_err++; $display("FAIL typeFF: got ty=%b cnt=%h want ty=0 cnt=1", blk_type_err, err_cnt);
        end
        drive(1'b1, SH_D, 64'h0);
        n_vec++;
        if (blk_type_err !== 1'b0 || err_cnt !== 4'd1) begin
            n_err++; $display("FAIL type_datahdr: got ty=%b cnt=%h want ty=0 cnt=1", blk_type_err, err_cnt);
        end
    endtask

    task automatic test_resync();
        clear_counter();
        resync = 1'b1;
        drive(1'b1, 2'b00, DATA);
        resync = 1'b0;
        n_vec++;
        if (desc_synced !== 1'b0 || sh_err !== 1'b1 || err_cnt !== 4'd0) begin
            n_err++; $display("FAIL resync_1st: got sync=%b sh=%b cnt=%h want 0 1 0", desc_synced, sh_err, err_cnt);
        end
        drive(1'b1, 2'b11, DATA);
        n_vec++;
        if (desc_synced !== 1'b0 || err_cnt !== 4'd0) begin
            n_err++; $display("FAIL resync_2nd: got sync=%b cnt=%h want 0 0", desc_synced, err_cnt);
        end
        drive(1'b1, SH_C, IDLE);
        n_vec++;
        if (desc_synced !== 1'b1 || desc_blk !== {IDLE, SH_C} || err_cnt !== 4'd0) begin
            n_err++; $display("FAIL resync_3rd: got sync=%b blk=%h cnt=%h want 1 %h 0", desc_synced, desc_blk, err_cnt, {IDLE, SH_C});
        end
    endtask

    task automatic test_counter_edges();
        clear_counter();
        for (int b = 1; b <= 17; b++) begin
            drive(1'b1, 2'b00, DATA);
            if (b == 14 || b == 15 || b == 17) begin
                n_vec++;
                if (err_cnt !== ((b == 14) ? 4'hE : 4'hF)) begin
                    n_err++; $display("FAIL sat blk%0d: got %h want %h", b, err_cnt, (b == 14) ? 4'hE : 4'hF);
                end
            end
        end
        cnt_clr = 1'b1;
        drive(1'b1, 2'b11, DATA);
        cnt_clr = 1'b0;
        n_vec++;
        if (err_cnt !== 4'h0 || sh_err !== 1'b1) begin
            n_err++; $display("FAIL clr_wins: got cnt=%h sh=%b want 0 1", err_cnt, sh_err);
        end
        drive(1'b1, 2'b00, DATA);
        rst_n = 1'b0;
        drive(1'b1, SH_C, IDLE);
        rst_n = 1'b1;
        n_vec++;
        if ({desc_blk, desc_blk_ena, desc_synced, sh_err, blk_type_err, err_cnt} !== 75'h0) begin
            n_err++; $display("FAIL midreset: got blk=%h ena=%b sync=%b sh=%b ty=%b cnt=%h want all 0",
                              desc_blk, desc_blk_ena, desc_synced, sh_err, blk_type_err, err_cnt);
        end
        drive(1'b1, SH_C, IDLE);
        n_vec++;
        if (desc_synced !== 1'b0 || desc_blk_ena !== 1'b1) begin
            n_err++; $display("FAIL post_reset_1st: got sync=%b ena=%b want 0 1", desc_synced, desc_blk_ena);
        end
        drive(1'b1, SH_C, IDLE);
        n_vec++;
        if (desc_synced !== 1'b1 || desc_blk !== {IDLE, SH_C}) begin
            n_err++; $display("FAIL post_reset_2nd: got sync=%b blk=%h want 1 %h", desc_synced, desc_blk, {IDLE, SH_C});
        end
    endtask

    initial begin
        pcs_blk = '0; pcs_blk_ena = 1'b0; tx_s = '0;
        test_reset();
        test_idle_stream();
        test_gaps();
        test_header_errors();
        test_illegal_type();
        test_resync();
        test_counter_edges();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
